garegga_snd_rom_arb: RTL and testbench

GAREGGA_SND_ROM_ARB -- requirements
Module: garegga_snd_rom_arb

---
 rtl/garegga_snd_pkg.sv | 16 +
 rtl/garegga_snd_rom_slot.sv | 36 +++
 rtl/garegga_snd_rom_arb.sv | 115 +++++++++++
 tb/tb_garegga_snd_rom_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/garegga_snd_pkg.sv
// Shared definitions for the Garegga sound ROM arbiter: FSM state encoding
// and the default SDRAM region offsets for the Z80 program and ADPCM samples.
package garegga_snd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_Z_REQ  = 3'd1,
        ST_Z_WAIT = 3'd2,
        ST_P_REQ  = 3'd3,
        ST_P_WAIT = 3'd4
    } snd_state_e;

    localparam logic [21:0] Z80_BASE_DEF = 22'h000000;
    localparam logic [21:0] PCM_BASE_DEF = 22'h020000;

endpackage

// File: rtl/garegga_snd_rom_slot.sv
// One-entry read cache: tag/data/valid register, combinational hit compare
// and a load port written only when an SDRAM fetch completes.
module garegga_snd_rom_slot #(
    parameter int AW = 17
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs_i,
    input  logic [AW-1:0] addr_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_tag_i,
    input  logic [7:0]    load_data_i,
    output logic          hit_o,
    output logic [7:0]    dout_o
);

    logic [AW-1:0] tag_q;
    logic [7:0]    data_q;
    logic          valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            tag_q   <= load_tag_i;
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end
    end

    assign hit_o  = cs_i && valid_q && (tag_q == addr_i);
    assign dout_o = data_q;

endmodule

// File: rtl/garegga_snd_rom_arb.sv
// Shares one SDRAM read port between the Z80 program ROM and the ADPCM ROM,
// each fronted by a one-byte slot; simultaneous misses alternate round-robin.
module garegga_snd_rom_arb
    import garegga_snd_pkg::*;
#(
    parameter logic [21:0] Z80_BASE = Z80_BASE_DEF,
    parameter logic [21:0] PCM_BASE = PCM_BASE_DEF
) (
    input  logic        CLK96,
    input  logic        RESET96,
    input  logic        Z80_CS,
    input  logic [16:0] Z80_ADDR,
    output logic        Z80_OK,
    output logic [7:0]  Z80_DOUT,
    input  logic        PCM_CS,
    input  logic [19:0] PCM_ADDR,
    output logic        PCM_OK,
    output logic [7:0]  PCM_DOUT,
    output logic        MEM_CS,
    output logic [21:0] MEM_ADDR,
    input  logic        MEM_OK,
    input  logic [7:0]  MEM_DOUT
);

    snd_state_e  state_q;
    logic        mem_cs_q;
    logic [21:0] mem_addr_q;
    logic [16:0] z_lat_q;
    logic [19:0] p_lat_q;
    logic        last_pcm_q;

    logic z_hit, p_hit, z_miss, p_miss, z_load, p_load;

    assign z_load = (state_q == ST_Z_WAIT) && MEM_OK;
    assign p_load = (state_q == ST_P_WAIT) && MEM_OK;

    garegga_snd_rom_slot #(.AW(17)) u_z80_slot (
        .clk_i       (CLK96),
        .rst_i       (RESET96),
        .cs_i        (Z80_CS),
        .addr_i      (Z80_ADDR),
        .load_i      (z_load),
        .load_tag_i  (z_lat_q),
        .load_data_i (MEM_DOUT),
        .hit_o       (z_hit),
        .dout_o      (Z80_DOUT)
    );

    garegga_snd_rom_slot #(.AW(20)) u_pcm_slot (
        .clk_i       (CLK96),
        .rst_i       (RESET96),
        .cs_i        (PCM_CS),
        .addr_i      (PCM_ADDR),
        .load_i      (p_load),
        .load_tag_i  (p_lat_q),
        .load_data_i (MEM_DOUT),
        .hit_o       (p_hit),
        .dout_o      (PCM_DOUT)
    );

    assign z_miss = Z80_CS && !z_hit;
    assign p_miss = PCM_CS && !p_hit;

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            state_q    <= ST_IDLE;
            mem_cs_q   <= 1'b0;
            mem_addr_q <= '0;
            z_lat_q    <= '0;
            p_lat_q    <= '0;
            last_pcm_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Z80 takes the port unless PCM also misses and Z80 went last.
                    if (z_miss && (!p_miss || last_pcm_q)) begin
                        state_q    <= ST_Z_REQ;
                        z_lat_q    <= Z80_ADDR;
                        mem_cs_q   <= 1'b1;
                        mem_addr_q <= Z80_BASE + {5'd0, Z80_ADDR};
                    end else if (p_miss) begin
                        state_q    <= ST_P_REQ;
                        p_lat_q    <= PCM_ADDR;
                        mem_cs_q   <= 1'b1;
                        mem_addr_q <= PCM_BASE + {2'd0, PCM_ADDR};
                    end
                end
                // MEM_OK may still be high from the previous access here.
                ST_Z_REQ: state_q <= ST_Z_WAIT;
                ST_P_REQ: state_q <= ST_P_WAIT;
                ST_Z_WAIT: begin
                    if (MEM_OK) begin
                        mem_cs_q   <= 1'b0;
                        last_pcm_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_P_WAIT: begin
                    if (MEM_OK) begin
                        mem_cs_q   <= 1'b0;
                        last_pcm_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Z80_OK   = z_hit;
    assign PCM_OK   = p_hit;
    assign MEM_CS   = mem_cs_q;
    assign MEM_ADDR = mem_addr_q;

endmodule

// File: tb/tb_garegga_snd_rom_arb.sv
// Bench for the sound ROM arbiter: an SDRAM responder model plus a queue of
// expected fetch addresses checked as each SDRAM request starts.
module tb_garegga_snd_rom_arb;

    logic        CLK96 = 1'b0;
    logic        RESET96 = 1'b1;
    logic        Z80_CS = 1'b0;
    logic [16:0] Z80_ADDR = '0;
    logic        Z80_OK;
    logic [7:0]  Z80_DOUT;
    logic        PCM_CS = 1'b0;
    logic [19:0] PCM_ADDR = '0;
    logic        PCM_OK;
    logic [7:0]  PCM_DOUT;
    logic        MEM_CS;
    logic [21:0] MEM_ADDR;
    logic        MEM_OK = 1'b0;
    logic [7:0]  MEM_DOUT = '0;

    int errors = 0;
    int checks = 0;

    logic [21:0] exp_addr_q[$];
    int          fetch_cnt = 0;
    logic        mem_cs_prev = 1'b0;
    logic [21:0] mem_addr_prev = '0;

    bit hold_ok = 1'b0;
    int resp_lat = 2;
    int resp_cnt = 0;

    garegga_snd_rom_arb dut (
        .CLK96    (CLK96),
        .RESET96  (RESET96),
        .Z80_CS   (Z80_CS),
        .Z80_ADDR (Z80_ADDR),
        .Z80_OK   (Z80_OK),
        .Z80_DOUT (Z80_DOUT),
        .PCM_CS   (PCM_CS),
        .PCM_ADDR (PCM_ADDR),
        .PCM_OK   (PCM_OK),
        .PCM_DOUT (PCM_DOUT),
        .MEM_CS   (MEM_CS),
        .MEM_ADDR (MEM_ADDR),
        .MEM_OK   (MEM_OK),
        .MEM_DOUT (MEM_DOUT)
    );

    always #5 CLK96 = ~CLK96;

    function automatic logic [7:0] mem_byte(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA4;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM model: data is registered so it lags MEM_ADDR by one cycle.
    always @(posedge CLK96) begin
        if (hold_ok) begin
            MEM_OK   <= 1'b1;
            MEM_DOUT <= mem_byte(MEM_ADDR);
        end else if (MEM_CS) begin
            if (resp_cnt + 1 >= resp_lat) begin
                MEM_OK   <= 1'b1;
                MEM_DOUT <= mem_byte(MEM_ADDR);
            end
            resp_cnt <= resp_cnt + 1;
        end else begin
            MEM_OK   <= 1'b0;
            resp_cnt <= 0;
        end
    end

    always @(negedge CLK96) begin
        if (MEM_CS && !mem_cs_prev) begin
            fetch_cnt++;
            $display("fetch #%0d MEM_ADDR=%06h", fetch_cnt, MEM_ADDR);
            if (exp_addr_q.size() == 0)
                check_val("unexpected_fetch", {10'd0, MEM_ADDR}, 32'hFFFF_FFFF);
            else
                check_val("fetch_addr", {10'd0, MEM_ADDR}, {10'd0, exp_addr_q.pop_front()});
        end else if (MEM_CS && mem_cs_prev) begin
            check_val("addr_stable", {10'd0, MEM_ADDR}, {10'd0, mem_addr_prev});
        end
        mem_cs_prev   = MEM_CS;
        mem_addr_prev = MEM_ADDR;
    end

    task automatic wait_ok(input bit pcm, output int edges);
        bit done;
        done  = 1'b0;
        edges = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge CLK96);
            edges++;
            if (pcm ? PCM_OK : Z80_OK) done = 1'b1;
        end
        if (!done) check_val(pcm ? "pcm_timeout" : "z80_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK96);
        RESET96 = 1'b1;
        repeat (2) @(negedge CLK96);
        RESET96 = 1'b0;
    endtask

    initial begin
        int edges;
        int fcnt0;

        // Reset state
        repeat (2) @(negedge CLK96);
        check_val("rst_z80_ok", {31'd0, Z80_OK}, 32'd0);
        check_val("rst_pcm_ok", {31'd0, PCM_OK}, 32'd0);
        check_val("rst_mem_cs", {31'd0, MEM_CS}, 32'd0);
        check_val("rst_mem_addr", {10'd0, MEM_ADDR}, 32'd0);
        RESET96 = 1'b0;

        // Basic Z80 miss with 2-cycle SDRAM latency
        @(negedge CLK96);
        resp_lat = 2;
        exp_addr_q.push_back(22'h000100);
        Z80_ADDR = 17'h00100;
        Z80_CS   = 1'b1;
        wait_ok(1'b0, edges);
        $display("z80 read %05h -> %02h after %0d edges", Z80_ADDR, Z80_DOUT, edges);
        check_val("z80_fill_data", {24'd0, Z80_DOUT}, 32'hA5);
        check_val("z80_fill_cs_drop", {31'd0, MEM_CS}, 32'd0);

        // Repeat read hits without touching SDRAM
        Z80_CS = 1'b0;
        @(negedge CLK96);
        Z80_CS = 1'b1;
        fcnt0  = fetch_cnt;
        #1;
        check_val("z80_hit_same_cycle", {31'd0, Z80_OK}, 32'd1);
        repeat (5) @(negedge CLK96);
        check_val("z80_hit_no_fetch", fetch_cnt - fcnt0, 32'd0);
        check_val("z80_hit_mem_cs", {31'd0, MEM_CS}, 32'd0);
        $display("z80 repeat read %05h -> hit", Z80_ADDR);

        // Simultaneous misses after reset: Z80 first, then round-robin to PCM
        do_reset();
        exp_addr_q.push_back(22'h000200);
        exp_addr_q.push_back(22'h020010);
        exp_addr_q.push_back(22'h000201);
        Z80_ADDR = 17'h00200;
        PCM_ADDR = 20'h00010;
        Z80_CS   = 1'b1;
        PCM_CS   = 1'b1;
        wait_ok(1'b0, edges);
        check_val("rr_z80_data", {24'd0, Z80_DOUT}, {24'd0, mem_byte(22'h000200)});
        check_val("rr_pcm_pending", {31'd0, PCM_OK}, 32'd0);
        $display("rr z80 read 00200 -> %02h", Z80_DOUT);
        Z80_ADDR = 17'h00201;
        wait_ok(1'b1, edges);
        check_val("rr_pcm_data", {24'd0, PCM_DOUT}, {24'd0, mem_byte(22'h020010)});
        check_val("rr_z80_pending", {31'd0, Z80_OK}, 32'd0);
        $display("rr pcm read 00010 -> %02h", PCM_DOUT);
        wait_ok(1'b0, edges);
        check_val("rr_z80_data2", {24'd0, Z80_DOUT}, {24'd0, mem_byte(22'h000201)});
        $display("rr z80 read 00201 -> %02h", Z80_DOUT);

        // MEM_OK held high: exactly 3 edges, data captured only in the wait state
        hold_ok = 1'b1;
        exp_addr_q.push_back(22'h000500);
        Z80_ADDR = 17'h00500;
        wait_ok(1'b0, edges);
        check_val("hold_z80_edges", edges, 32'd3);
        check_val("hold_z80_data", {24'd0, Z80_DOUT}, {24'd0, mem_byte(22'h000500)});
        $display("hold z80 read 00500 -> %02h in %0d edges", Z80_DOUT, edges);
        exp_addr_q.push_back(22'h020030);
        PCM_ADDR = 20'h00030;
        wait_ok(1'b1, edges);
        check_val("hold_pcm_edges", edges, 32'd3);
        check_val("hold_pcm_data", {24'd0, PCM_DOUT}, {24'd0, mem_byte(22'h020030)});
        $display("hold pcm read 00030 -> %02h in %0d edges", PCM_DOUT, edges);
        hold_ok = 1'b0;
        PCM_CS  = 1'b0;
        repeat (3) @(negedge CLK96);

        // Address change mid-fetch: first fetch completes, second is issued
        resp_lat = 4;
        fcnt0    = fetch_cnt;
        exp_addr_q.push_back(22'h000300);
        exp_addr_q.push_back(22'h000301);
        Z80_ADDR = 17'h00300;
        repeat (2) @(negedge CLK96);
        Z80_ADDR = 17'h00301;
        wait_ok(1'b0, edges);
        check_val("chg_z80_data", {24'd0, Z80_DOUT}, {24'd0, mem_byte(22'h000301)});
        check_val("chg_fetches", fetch_cnt - fcnt0, 32'd2);
        $display("addr change read 00301 -> %02h, %0d fetches", Z80_DOUT, fetch_cnt - fcnt0);

        // Reset during a PCM fetch
        Z80_CS   = 1'b0;
        resp_lat = 6;
        exp_addr_q.push_back(22'h020040);
        PCM_ADDR = 20'h00040;
        PCM_CS   = 1'b1;
        repeat (3) @(negedge CLK96);
        RESET96 = 1'b1;
        #1;
        check_val("midrst_mem_cs", {31'd0, MEM_CS}, 32'd0);
        check_val("midrst_pcm_ok", {31'd0, PCM_OK}, 32'd0);
        @(negedge CLK96);
        check_val("midrst_mem_addr", {10'd0, MEM_ADDR}, 32'd0);
        exp_addr_q.push_back(22'h020040);
        RESET96 = 1'b0;
        wait_ok(1'b1, edges);
        check_val("midrst_refetch_data", {24'd0, PCM_DOUT}, {24'd0, mem_byte(22'h020040)});
        $display("post-reset pcm read 00040 -> %02h", PCM_DOUT);

        PCM_CS = 1'b0;
        repeat (4) @(negedge CLK96);
        check_val("fetch_queue_empty", exp_addr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
